apb_regfile_slave: RTL and testbench

APB completer that consumes transfers issued by the team's APB master. It decodes a word-aligned window at BASE_ADDR into NUM_REGS 32-bit registers. It inserts a programmable number of wait states and flags illegal accesses with pslverr. The last register is a read-only count of completed transfers, and register 0 is exported as a control word to downstream logic.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_addr_decode.sv | 39 +++
 rtl/apb_regfile_slave.sv | 151 +++++++++++++++
 tb/tb_apb_regfile_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB completers in this codebase.
//   - Bus widths for address and data.
//   - Default register window base address.
//   - State encoding used by the register-file completer FSM.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam logic [APB_AW-1:0] DEF_BASE_ADDR = 32'h0000_1000;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder for a word-aligned register window.
// Ports:
//   paddr  in  byte address from the APB setup phase
//   pwrite in  1 = write
//   idx    out register index, (paddr - BASE_ADDR) >> 2 truncated to IW bits
//   err    out access is illegal (out of window, misaligned, or a write to
//              the read-only last register)
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int NUM_REGS = 8,
  parameter int IW = $clog2(NUM_REGS)
) (
  input  logic [APB_AW-1:0] paddr,
  input  logic              pwrite,
  output logic [IW-1:0]     idx,
  output logic              err
);

  // End of the window, one bit wider so a window touching the top of the
  // address space cannot wrap and make the compare pass.
  localparam logic [APB_AW:0] END_ADDR = {1'b0, BASE_ADDR} + (APB_AW+1)'(4 * NUM_REGS);
  localparam logic [IW-1:0]   RO_IDX   = IW'(NUM_REGS - 1);

  logic below;
  logic above;
  logic misaligned;
  logic ro_write;

  assign idx        = IW'((paddr - BASE_ADDR) >> 2);
  // Range checks use the full address, never the truncated index.
  assign below      = paddr < BASE_ADDR;
  assign above      = {1'b0, paddr} >= END_ADDR;
  assign misaligned = paddr[1:0] != 2'b00;
  assign ro_write   = pwrite && (idx == RO_IDX);
  assign err        = below || above || misaligned || ro_write;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer exposing NUM_REGS 32-bit registers at BASE_ADDR.
// Register NUM_REGS-1 is a read-only count of completed transfers; register 0
// is exported on ctrl_q. WAIT_STATES extra access cycles precede pready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata              APB address / write data
//   prdata, pready, pslverr    APB response (registered)
//   ctrl_q                     current value of register 0
// Handshake: a transfer is accepted in the setup phase (psel=1, penable=0)
// and completes in the access-phase cycle where pready=1; the write and the
// counter increment happen at the end of that cycle, while psel=penable=1.
// Dropping psel before pready aborts the transfer with no side effects.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [APB_DW-1:0] ctrl_q
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] CNT_IDX = IW'(NUM_REGS - 1);
  localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]        state;
  logic [3:0]        wcnt;
  logic [IW-1:0]     idx_q;
  logic              wr_q;
  logic              err_q;
  logic [APB_DW-1:0] regs [NUM_REGS];

  logic [IW-1:0]     dec_idx;
  logic              dec_err;

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IW        (IW)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .idx    (dec_idx),
    .err    (dec_err)
  );

  // Transition into DONE. With zero wait states this happens straight from
  // the setup phase, so the live decode is used instead of the latched one.
  logic              go_done;
  logic [IW-1:0]     done_idx;
  logic              done_wr;
  logic              done_err;
  logic [APB_DW-1:0] done_rdata;

  always_comb begin
    go_done  = 1'b0;
    done_idx = idx_q;
    done_wr  = wr_q;
    done_err = err_q;
    case (state)
      ST_IDLE: begin
        if (psel && !penable && (WAIT_STATES == 0)) begin
          go_done  = 1'b1;
          done_idx = dec_idx;
          done_wr  = pwrite;
          done_err = dec_err;
        end
      end
      ST_WAIT: begin
        if (psel && (wcnt == 4'd0)) go_done = 1'b1;
      end
      default: ;
    endcase
    // Counter reads see the pre-increment value because the increment lands
    // at the end of the DONE cycle, after this capture.
    done_rdata = (!done_err && !done_wr) ? regs[done_idx] : '0;
  end

  logic complete;
  assign complete = (state == ST_DONE) && psel && penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wcnt    <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      if (go_done) begin
        pready  <= 1'b1;
        pslverr <= done_err;
        prdata  <= done_rdata;
      end
      case (state)
        ST_IDLE: begin
          // penable without a prior setup phase is ignored here.
          if (psel && !penable) begin
            idx_q <= dec_idx;
            wr_q  <= pwrite;
            err_q <= dec_err;
            if (WAIT_STATES == 0) begin
              state <= ST_DONE;
            end else begin
              wcnt  <= WS_M1;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!psel)              state <= ST_IDLE;
          else if (wcnt == 4'd0)  state <= ST_DONE;
          else                    wcnt  <= wcnt - 4'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register array. Write data is sampled live in the DONE cycle; the error
  // flag already excludes writes to the counter slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (complete) begin
      if (!err_q && wr_q) regs[idx_q] <= pwdata;
      regs[CNT_IDX] <= regs[CNT_IDX] + 32'd1;
    end
  end

  assign ctrl_q = regs[0];

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int NREG = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared APB bus, routed to one of two builds ----------------
  logic        sel = 1'b1;   // 1: WAIT_STATES=1 build, 0: WAIT_STATES=0 build
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic        psel1, psel0;
  logic [31:0] prdata1, prdata0, ctrl1, ctrl0;
  logic        pready1, pready0, pslverr1, pslverr0;
  logic [31:0] prdata, ctrl_q;
  logic        pready, pslverr;

  assign psel1   = psel & sel;
  assign psel0   = psel & ~sel;
  assign prdata  = sel ? prdata1  : prdata0;
  assign pready  = sel ? pready1  : pready0;
  assign pslverr = sel ? pslverr1 : pslverr0;
  assign ctrl_q  = sel ? ctrl1    : ctrl0;

  apb_regfile_slave #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .ctrl_q(ctrl1)
  );

  apb_regfile_slave #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .ctrl_q(ctrl0)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_regs [2][NREG];
  logic [31:0] m_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      for (int i = 0; i < NREG; i++) m_regs[s][i] = 0;
    end
  endtask

  // Whole-transfer view: legality from plain address arithmetic, then the
  // effect on the register image and the completed-transfer count.
  task automatic model_xfer(input int s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] exp_rd,
                            output logic exp_err);
    logic in_win;
    int i;
    in_win  = (addr >= BASE) && (addr < BASE + 4 * NREG) && (addr % 4 == 0);
    i       = in_win ? int'((addr - BASE) / 4) : 0;
    exp_err = !in_win || (wr && i == NREG - 1);
    exp_rd  = 0;
    if (!exp_err && !wr) exp_rd = (i == NREG - 1) ? m_cnt[s] : m_regs[s][i];
    if (!exp_err && wr) m_regs[s][i] = data;
    m_cnt[s] = m_cnt[s] + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    psel = 0;
    penable = 0;
    repeat (n) step();
  endtask

  // Setup phase, access phase until pready (bounded), then the completing
  // edge. Leaves psel high so a following call is back-to-back.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic err, output int lat);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    step();
    penable = 1;
    lat = 1;
    while (!pready && lat < 32) begin
      step();
      lat++;
    end
    if (!pready) chk("pready_timeout", 32'(pready), 32'd1);
    rd  = prdata;
    err = pslverr;
    step();
  endtask

  task automatic do_xfer(input string tag, input logic s, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd, e_rd;
    logic err, e_err;
    int lat;
    sel = s;
    model_xfer(int'(s), wr, addr, data, e_rd, e_err);
    exp_q.push_back(e_rd);
    xfer(wr, addr, data, rd, err, lat);
    chk({tag, "_lat"}, 32'(lat), s ? 32'd2 : 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_rdata"}, rd, exp_q.pop_front());
    chk({tag, "_ctrl"}, ctrl_q, m_regs[s][0]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd, addr;
    logic err;
    int lat, c0, r;

    model_reset();
    repeat (3) step();
    chk("rst_prdata1", prdata1, 32'd0);
    chk("rst_pready1", 32'(pready1), 32'd0);
    chk("rst_pslverr1", 32'(pslverr1), 32'd0);
    chk("rst_ctrl1", ctrl1, 32'd0);
    chk("rst_pready0", 32'(pready0), 32'd0);
    chk("rst_ctrl0", ctrl0, 32'd0);
    rst_n = 1;
    step();

    // write to register 0, one wait state
    do_xfer("t1_wr", 1'b1, 1'b1, 32'h1000, 32'hA5A5_A5A5);
    chk("t1_ctrl_const", ctrl_q, 32'hA5A5_A5A5);
    idle(1);

    // counter reads: only the earlier write counted, then back-to-back
    do_xfer("t3_cnt_a", 1'b1, 1'b0, 32'h101C, 32'h0);
    do_xfer("t3_cnt_b", 1'b1, 1'b0, 32'h101C, 32'h0);
    idle(1);

    do_xfer("t2_rd0", 1'b1, 1'b0, 32'h1000, 32'h0);
    idle(1);

    // illegal accesses
    do_xfer("t4_wr_cnt", 1'b1, 1'b1, 32'h101C, 32'hDEAD_BEEF);
    do_xfer("t4_rd_hi", 1'b1, 1'b0, 32'h1020, 32'h0);
    do_xfer("t4_rd_lo", 1'b1, 1'b0, 32'h0FFC, 32'h0);
    do_xfer("t4_wr_mis", 1'b1, 1'b1, 32'h1002, 32'h1234_5678);
    do_xfer("t4_rd0", 1'b1, 1'b0, 32'h1000, 32'h0);
    do_xfer("t4_cnt", 1'b1, 1'b0, 32'h101C, 32'h0);
    idle(1);

    // zero-wait build, back-to-back writes
    sel = 0;
    c0 = cyc;
    do_xfer("t5_wr1", 1'b0, 1'b1, 32'h1004, 32'h1111_0004);
    do_xfer("t5_wr2", 1'b0, 1'b1, 32'h1008, 32'h2222_0008);
    chk("t5_b2b_cycles", 32'(cyc - c0), 32'd4);
    do_xfer("t5_rd1", 1'b0, 1'b0, 32'h1004, 32'h0);
    do_xfer("t5_rd2", 1'b0, 1'b0, 32'h1008, 32'h0);
    idle(1);

    // penable without setup is ignored
    sel = 1; psel = 1; penable = 1; pwrite = 1; paddr = 32'h1000; pwdata = 32'h0BAD_0BAD;
    repeat (3) begin
      step();
      chk("t6_noset_pready", 32'(pready), 32'd0);
    end
    idle(1);
    chk("t6_noset_ctrl", ctrl_q, m_regs[1][0]);

    // abort during the wait state
    sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h1000; pwdata = 32'h5555_5555;
    step();
    penable = 1;
    chk("t6_abort_wait", 32'(pready), 32'd0);
    psel = 0; penable = 0;
    repeat (3) begin
      step();
      chk("t6_abort_pready", 32'(pready), 32'd0);
    end
    do_xfer("t6_abort_cnt", 1'b1, 1'b0, 32'h101C, 32'h0);
    idle(1);

    // reset in the DONE cycle of a write to register 0
    sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h1000; pwdata = 32'h7777_7777;
    step();
    penable = 1;
    step();
    chk("t6_done_pready", 32'(pready), 32'd1);
    rst_n = 0;
    #1;
    chk("t6_rst_pready", 32'(pready), 32'd0);
    chk("t6_rst_pslverr", 32'(pslverr), 32'd0);
    chk("t6_rst_prdata", prdata, 32'd0);
    chk("t6_rst_ctrl", ctrl_q, 32'd0);
    model_reset();
    psel = 0; penable = 0;
    repeat (2) step();
    rst_n = 1;
    step();
    do_xfer("t6_rst_rd0", 1'b1, 1'b0, 32'h1000, 32'h0);
    chk("t6_rst_ctrl_after", ctrl_q, 32'd0);
    idle(1);

    // randomized traffic on both builds
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       addr = BASE + 4 * $urandom_range(0, NREG - 1);
      else if (r == 7) addr = BASE + $urandom_range(0, 4 * NREG - 1);
      else if (r == 8) addr = BASE + 4 * NREG + 4 * $urandom_range(0, 3);
      else             addr = $urandom();
      do_xfer("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom());
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
